// File: rtl/dest_reg_tracker.sv
// Carries each instruction's destination register and load flag through ID/EX, EX/MEM and MEM/WB
// for the hazard unit, inserting bubbles on stall/flush and holding EX while a multi-cycle op runs.
module dest_reg_tracker #(
    parameter int REG_ADDR_W  = 5,
    parameter int MUL_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] Rw_ID,
    input  logic                  RegWr_ID,
    input  logic                  LD_ID,
    input  logic                  MUL_ID,
    input  logic                  Stall_ID,
    input  logic                  Flush_ID,
    output logic [REG_ADDR_W-1:0] Rw_ID_EX,
    output logic                  LD_ID_EX,
    output logic [REG_ADDR_W-1:0] Rw_EX_MEM,
    output logic [REG_ADDR_W-1:0] Rw_MEM_WB,
    output logic                  Stall_Front,
    output logic                  EX_Busy
);

    localparam int CNT_W = $clog2(MUL_LATENCY) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        mul_cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic                    accept;
    logic [REG_ADDR_W-1:0]   rw_in;
    logic                    ld_in;

    logic                    vld_p0, vld_p1, vld_p2;
    logic [REG_ADDR_W-1:0]   rw_p0, rw_p1, rw_p2;
    logic                    ld_p0;

    // Non-writing instructions travel with rw=0 so they can never match a source register.
    assign rw_in = RegWr_ID ? Rw_ID : '0;
    assign ld_in = LD_ID && (rw_in != '0);

    assign state = (mul_cnt == '0) ? IDLE : BUSY;

    always_comb begin
        cnt_next = mul_cnt;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                accept = !(Stall_ID || Flush_ID);
                if (accept && MUL_ID && (MUL_LATENCY > 1))
                    cnt_next = CNT_W'(MUL_LATENCY - 1);
            end
            BUSY: begin
                cnt_next = mul_cnt - CNT_W'(1);
            end
            default: cnt_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_cnt <= '0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
        end else begin
            mul_cnt <= cnt_next;
            // MEM/WB boundary
            vld_p2  <= vld_p1;
            if (state == BUSY) begin
                // EX/MEM boundary: EX is occupied, so a bubble drains downstream
                vld_p1 <= 1'b0;
            end else begin
                vld_p1 <= vld_p0;
                // ID/EX boundary
                vld_p0 <= accept;
            end
        end
    end

    always_ff @(posedge clk) begin
        rw_p2 <= rw_p1;
        if (state == IDLE)
            rw_p1 <= rw_p0;
        if (accept) begin
            rw_p0 <= rw_in;
            ld_p0 <= ld_in;
        end
    end

    assign Rw_ID_EX    = vld_p0 ? rw_p0 : '0;
    assign LD_ID_EX    = vld_p0 && ld_p0;
    assign Rw_EX_MEM   = vld_p1 ? rw_p1 : '0;
    assign Rw_MEM_WB   = vld_p2 ? rw_p2 : '0;
    assign EX_Busy     = (state == BUSY);
    assign Stall_Front = Stall_ID || (state == BUSY);

endmodule

// File: tb/tb_dest_reg_tracker.sv
// Directed and randomized checks of dest_reg_tracker against a stage-list reference model.
module tb_dest_reg_tracker;

    localparam int AW = 5;
    localparam int L  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] Rw_ID;
    logic          RegWr_ID, LD_ID, MUL_ID, Stall_ID, Flush_ID;
    logic [AW-1:0] Rw_ID_EX, Rw_EX_MEM, Rw_MEM_WB;
    logic          LD_ID_EX, Stall_Front, EX_Busy;

    int total  = 0;
    int passed = 0;

    // Reference: destination register held by each pipeline register (0 = bubble/no write),
    // load flag of ID/EX, and number of edges EX remains occupied.
    int m_rw[3];
    int m_ld;
    int m_rem;

    dest_reg_tracker #(.REG_ADDR_W(AW), .MUL_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .Rw_ID(Rw_ID), .RegWr_ID(RegWr_ID), .LD_ID(LD_ID),
        .MUL_ID(MUL_ID), .Stall_ID(Stall_ID), .Flush_ID(Flush_ID),
        .Rw_ID_EX(Rw_ID_EX), .LD_ID_EX(LD_ID_EX), .Rw_EX_MEM(Rw_EX_MEM),
        .Rw_MEM_WB(Rw_MEM_WB), .Stall_Front(Stall_Front), .EX_Busy(EX_Busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_rw[0] = 0; m_rw[1] = 0; m_rw[2] = 0; m_ld = 0; m_rem = 0;
    endtask

    task automatic model_edge(input int rw, input int wr, input int ld, input int mul,
                              input int stall, input int flush);
        int dest;
        m_rw[2] = m_rw[1];
        if (m_rem > 0) begin
            m_rw[1] = 0;
            m_rem   = m_rem - 1;
        end else begin
            m_rw[1] = m_rw[0];
            if (stall != 0 || flush != 0) begin
                m_rw[0] = 0;
                m_ld    = 0;
            end else begin
                dest    = (wr != 0) ? rw : 0;
                m_rw[0] = dest;
                m_ld    = (ld != 0 && dest != 0) ? 1 : 0;
                if (mul != 0 && L > 1) m_rem = L - 1;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_rw_idex"},  int'(Rw_ID_EX),  m_rw[0]);
        chk({tag, "_ld_idex"},  int'(LD_ID_EX),  m_ld);
        chk({tag, "_rw_exmem"}, int'(Rw_EX_MEM), m_rw[1]);
        chk({tag, "_rw_memwb"}, int'(Rw_MEM_WB), m_rw[2]);
        chk({tag, "_busy"},     int'(EX_Busy),   (m_rem > 0) ? 1 : 0);
    endtask

    // Called just after a rising edge; drives inputs, checks the combinational stall,
    // takes one edge and checks registered outputs against the model.
    task automatic step(input string tag, input int rw, input int wr, input int ld,
                        input int mul, input int stall, input int flush);
        Rw_ID    = AW'(rw);
        RegWr_ID = wr[0];
        LD_ID    = ld[0];
        MUL_ID   = mul[0];
        Stall_ID = stall[0];
        Flush_ID = flush[0];
        #1;
        chk({tag, "_stall_front"}, int'(Stall_Front), (stall != 0 || m_rem > 0) ? 1 : 0);
        @(posedge clk);
        model_edge(rw, wr, ld, mul, stall, flush);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        Rw_ID = '0; RegWr_ID = 1'b0; LD_ID = 1'b0; MUL_ID = 1'b0; Stall_ID = 1'b0; Flush_ID = 1'b0;
        model_reset();
        #2;
        check_outputs("reset");
        chk("reset_stall_front", int'(Stall_Front), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single writer flows through all three stages
        step("t2_e0", 3, 1, 0, 0, 0, 0);
        chk("t2_idex", int'(Rw_ID_EX), 3);
        step("t2_e1", 0, 0, 0, 0, 0, 0);
        chk("t2_exmem", int'(Rw_EX_MEM), 3);
        step("t2_e2", 0, 0, 0, 0, 0, 0);
        chk("t2_memwb", int'(Rw_MEM_WB), 3);

        // Load-use bubble
        step("t3_e0", 7, 1, 1, 0, 0, 0);
        chk("t3_ld", int'(LD_ID_EX), 1);
        step("t3_e1", 8, 1, 0, 0, 1, 0);
        chk("t3_bub_rw", int'(Rw_ID_EX), 0);
        chk("t3_bub_ld", int'(LD_ID_EX), 0);
        chk("t3_exmem", int'(Rw_EX_MEM), 7);

        // Multi-cycle op holds ID/EX for L cycles
        step("t4_e0", 9, 1, 0, 1, 0, 0);
        for (int i = 1; i < L; i++) begin
            chk("t4_hold", int'(Rw_ID_EX), 9);
            chk("t4_busy", int'(EX_Busy), 1);
            step("t4_bsy", 12, 1, 0, 0, 0, 0);
            chk("t4_exmem_bub", int'(Rw_EX_MEM), 0);
        end
        chk("t4_last_hold", int'(Rw_ID_EX), 9);
        chk("t4_idle", int'(EX_Busy), 0);
        step("t4_out", 13, 1, 0, 0, 0, 0);
        chk("t4_exmem", int'(Rw_EX_MEM), 9);

        // R0 and non-writing instructions carry rw=0
        step("t5_r0", 0, 1, 1, 0, 0, 0);
        chk("t5_r0_rw", int'(Rw_ID_EX), 0);
        chk("t5_r0_ld", int'(LD_ID_EX), 0);
        step("t5_nowr", 5, 0, 0, 0, 0, 0);
        chk("t5_nowr_rw", int'(Rw_ID_EX), 0);

        // Stall and flush together: one bubble; flush while busy is ignored
        step("t6_pre", 4, 1, 0, 0, 0, 0);
        step("t6_sf", 6, 1, 0, 0, 1, 1);
        chk("t6_sf_rw", int'(Rw_ID_EX), 0);
        chk("t6_sf_exmem", int'(Rw_EX_MEM), 4);
        step("t6_mul", 10, 1, 0, 1, 0, 0);
        step("t6_fl1", 11, 1, 0, 0, 0, 1);
        chk("t6_fl_hold", int'(Rw_ID_EX), 10);
        step("t6_fl2", 11, 1, 0, 0, 1, 1);
        step("t6_fl3", 11, 1, 0, 0, 0, 1);
        chk("t6_fl_done", int'(EX_Busy), 0);
        chk("t6_fl_hold2", int'(Rw_ID_EX), 10);

        // Asynchronous reset mid-multiply with two busy edges left
        step("t1_mul", 9, 1, 1, 1, 0, 0);
        step("t1_b1", 2, 1, 0, 0, 0, 0);
        chk("t1_busy_before", int'(EX_Busy), 1);
        Stall_ID = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("t1_rst");
        chk("t1_sf_hi", int'(Stall_Front), 1);
        Stall_ID = 1'b0;
        #1;
        chk("t1_sf_lo", int'(Stall_Front), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("t1_after", 14, 1, 0, 0, 0, 0);
        chk("t1_after_busy", int'(EX_Busy), 0);

        // Randomized traffic, including back-to-back multi-cycle ops
        for (int n = 0; n < 400; n++) begin
            int rw, wr, ld, mul, st, fl;
            rw  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 31));
            wr  = ($urandom_range(0, 4) != 0) ? 1 : 0;
            ld  = int'($urandom_range(0, 1));
            mul = ($urandom_range(0, 5) == 0) ? 1 : 0;
            st  = ($urandom_range(0, 4) == 0) ? 1 : 0;
            fl  = ($urandom_range(0, 7) == 0) ? 1 : 0;
            step("rnd", rw, wr, ld, mul, st, fl);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
